// File: rtl/exec_req_scheduler.sv
// exec_req_scheduler: round-robin front end for the execution unit.
// Shares the unit among NUM_REQ clients, allocates the eight 3-bit request
// IDs (lowest free first), records which client owns each ID so responses
// are routed back, and offers a flush/drain handshake.
// Optional feature: define SCHED_TIMEOUT_EN to add per-ID age counters that
// force-free an ID left unanswered for TIMEOUT_CYC cycles.
module exec_req_scheduler #(
  parameter int NUM_REQ     = 4,
  parameter int MAX_OUTST   = 4,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                      clk_i,
  input  logic                      rst_b_i,
  input  logic [NUM_REQ-1:0]        cl_req_i,
  input  logic [NUM_REQ-1:0]        cl_type_i,
  input  logic [NUM_REQ*DATA_W-1:0] cl_data1_i,
  input  logic [NUM_REQ*DATA_W-1:0] cl_data2_i,
  output logic [NUM_REQ-1:0]        cl_grant_o,
  output logic [NUM_REQ-1:0]        cl_rsp_o,
  output logic [63:0]               cl_rsp_data_o,
  output logic                      exe_req_req_o,
  output logic                      exe_req_type_o,
  output logic [2:0]                exe_req_id_o,
  output logic [DATA_W-1:0]         exe_req_data1_o,
  output logic [DATA_W-1:0]         exe_req_data2_o,
  input  logic                      exe_fifo_full_i,
  input  logic                      exe_rsp_rsp_i,
  input  logic [2:0]                exe_rsp_id_i,
  input  logic [63:0]               exe_rsp_data_i,
  input  logic                      flush_req_i,
  output logic                      flush_done_o,
  output logic                      err_spurious_o,
  output logic                      err_timeout_o
);

  localparam int NUM_ID = 8;
  localparam int PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W  = $clog2(MAX_OUTST + 1);

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [NUM_ID-1:0] busy_q, busy_d;
  logic [PTR_W-1:0]  owner_q [NUM_ID];
  logic [PTR_W-1:0]  owner_d [NUM_ID];
  logic [CNT_W-1:0]  outst_q [NUM_REQ];
  logic [CNT_W-1:0]  outst_d [NUM_REQ];
  logic [PTR_W-1:0]  rr_q, rr_d;

  logic [NUM_REQ-1:0] elig;
  logic               free_found;
  logic [2:0]         free_id;
  logic               win_found;
  logic [PTR_W-1:0]   win;
  logic               issue;
  logic               rsp_hit;
  logic [PTR_W-1:0]   rsp_owner;
  logic [NUM_ID-1:0]  timeout_vec;
  logic [NUM_ID-1:0]  free_vec;

  // Eligibility, lowest free ID and round-robin winner search.
  // NOTE: combinational blocks use blocking '=' and give every output a
  // default first, so no latch can be inferred on any path.
  always_comb begin
    elig = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      elig[i] = cl_req_i[i] && (outst_q[i] < CNT_W'(MAX_OUTST));
    end
    free_found = 1'b0;
    free_id    = '0;
    for (int j = NUM_ID - 1; j >= 0; j--) begin
      if (!busy_q[j]) begin
        free_found = 1'b1;
        free_id    = 3'(j);
      end
    end
    win_found = 1'b0;
    win       = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!win_found && elig[(int'(rr_q) + k) % NUM_REQ]) begin
        win_found = 1'b1;
        win       = PTR_W'((int'(rr_q) + k) % NUM_REQ);
      end
    end
    issue = (state_q == ST_RUN) && !exe_fifo_full_i && free_found && win_found;
  end

  // Grant and packet to the execution unit, same cycle as the decision.
  always_comb begin
    cl_grant_o      = '0;
    exe_req_req_o   = 1'b0;
    exe_req_type_o  = 1'b0;
    exe_req_id_o    = '0;
    exe_req_data1_o = '0;
    exe_req_data2_o = '0;
    if (issue) begin
      cl_grant_o[win] = 1'b1;
      exe_req_req_o   = 1'b1;
      exe_req_type_o  = cl_type_i[win];
      exe_req_id_o    = free_id;
      exe_req_data1_o = cl_data1_i[int'(win)*DATA_W +: DATA_W];
      exe_req_data2_o = cl_data2_i[int'(win)*DATA_W +: DATA_W];
    end
  end

  // Route a response for a busy ID back to its owner; flag free-ID responses.
  always_comb begin
    rsp_hit        = exe_rsp_rsp_i && busy_q[exe_rsp_id_i];
    rsp_owner      = owner_q[exe_rsp_id_i];
    err_spurious_o = exe_rsp_rsp_i && !busy_q[exe_rsp_id_i];
    cl_rsp_o       = '0;
    cl_rsp_data_o  = '0;
    if (rsp_hit) begin
      cl_rsp_o[rsp_owner] = 1'b1;
      cl_rsp_data_o       = exe_rsp_data_i;
    end
  end

`ifdef SCHED_TIMEOUT_EN
  localparam int AGE_W = $clog2(TIMEOUT_CYC + 1);
  logic [AGE_W-1:0] age_q [NUM_ID];

  // An ID expires in the cycle its age would reach TIMEOUT_CYC; a genuine
  // response to that ID in the same cycle takes precedence.
  always_comb begin
    timeout_vec = '0;
    for (int j = 0; j < NUM_ID; j++) begin
      timeout_vec[j] = busy_q[j] && (age_q[j] == AGE_W'(TIMEOUT_CYC - 1))
                       && !(rsp_hit && (exe_rsp_id_i == 3'(j)));
    end
  end

  // Age counters: cleared when an ID is allocated, count while it is busy.
  always_ff @(posedge clk_i or negedge rst_b_i) begin
    if (!rst_b_i) begin
      for (int j = 0; j < NUM_ID; j++) age_q[j] <= '0;
    end else begin
      for (int j = 0; j < NUM_ID; j++) begin
        if (issue && (free_id == 3'(j))) age_q[j] <= '0;
        else if (busy_q[j])              age_q[j] <= age_q[j] + AGE_W'(1);
      end
    end
  end
`else
  assign timeout_vec = '0;
`endif

  assign err_timeout_o = |timeout_vec;
  assign flush_done_o  = (state_q == ST_DONE);

  // Next-state: free answered/expired IDs, allocate on issue, move the
  // pointer past the winner, and step the drain state machine.
  always_comb begin
    free_vec = timeout_vec;
    if (rsp_hit) free_vec[exe_rsp_id_i] = 1'b1;
    busy_d  = busy_q & ~free_vec;
    owner_d = owner_q;
    outst_d = outst_q;
    for (int j = 0; j < NUM_ID; j++) begin
      if (free_vec[j]) outst_d[owner_q[j]] = outst_d[owner_q[j]] - CNT_W'(1);
    end
    rr_d = rr_q;
    if (issue) begin
      busy_d[free_id]  = 1'b1;
      owner_d[free_id] = win;
      outst_d[win]     = outst_d[win] + CNT_W'(1);
      rr_d             = (int'(win) == NUM_REQ - 1) ? '0 : win + PTR_W'(1);
    end
    state_d = state_q;
    case (state_q)
      ST_RUN:   if (flush_req_i) state_d = ST_DRAIN;
      // Done once every ID is free after this cycle's responses/expiries.
      ST_DRAIN: if (busy_d == '0) state_d = ST_DONE;
      ST_DONE:  state_d = ST_RUN;
      default:  state_d = ST_RUN;
    endcase
  end

  // State registers.
  // NOTE: sequential state uses non-blocking '<=' so every register samples
  // the values from before the edge, independent of statement order.
  always_ff @(posedge clk_i or negedge rst_b_i) begin
    if (!rst_b_i) begin
      state_q <= ST_RUN;
      busy_q  <= '0;
      rr_q    <= '0;
      // NOTE: the small owner/outstanding tables are reset explicitly because
      // a reset must discard all in-flight tracking, not just the busy bits.
      for (int j = 0; j < NUM_ID; j++)  owner_q[j] <= '0;
      for (int i = 0; i < NUM_REQ; i++) outst_q[i] <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      rr_q    <= rr_d;
      owner_q <= owner_d;
      outst_q <= outst_d;
    end
  end

endmodule

// File: tb/tb_exec_req_scheduler.sv
// Self-checking bench for exec_req_scheduler: a per-cycle reference model
// of ID ownership, round-robin order and drain phases, plus directed
// vectors with hand-computed expectations.
module tb_exec_req_scheduler;

  localparam int N  = 4;
  localparam int MO = 4;
  localparam int DW = 32;
  localparam int TO = 10;

  logic            clk = 1'b0;
  logic            rst_b;
  logic [N-1:0]    cl_req, cl_type, cl_grant, cl_rsp;
  logic [N*DW-1:0] cl_data1, cl_data2;
  logic [63:0]     cl_rsp_data;
  logic            exe_req_req, exe_req_type;
  logic [2:0]      exe_req_id;
  logic [DW-1:0]   exe_req_data1, exe_req_data2;
  logic            exe_fifo_full;
  logic            exe_rsp_rsp;
  logic [2:0]      exe_rsp_id;
  logic [63:0]     exe_rsp_data;
  logic            flush_req, flush_done, err_spurious, err_timeout;

  always #5 clk = ~clk;

  exec_req_scheduler #(
    .NUM_REQ(N), .MAX_OUTST(MO), .DATA_W(DW), .TIMEOUT_CYC(TO)
  ) dut (
    .clk_i(clk), .rst_b_i(rst_b),
    .cl_req_i(cl_req), .cl_type_i(cl_type),
    .cl_data1_i(cl_data1), .cl_data2_i(cl_data2),
    .cl_grant_o(cl_grant), .cl_rsp_o(cl_rsp), .cl_rsp_data_o(cl_rsp_data),
    .exe_req_req_o(exe_req_req), .exe_req_type_o(exe_req_type),
    .exe_req_id_o(exe_req_id), .exe_req_data1_o(exe_req_data1),
    .exe_req_data2_o(exe_req_data2),
    .exe_fifo_full_i(exe_fifo_full),
    .exe_rsp_rsp_i(exe_rsp_rsp), .exe_rsp_id_i(exe_rsp_id),
    .exe_rsp_data_i(exe_rsp_data),
    .flush_req_i(flush_req), .flush_done_o(flush_done),
    .err_spurious_o(err_spurious), .err_timeout_o(err_timeout)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // m_owner[id] = owning client, or -1 when the ID is free.
  int m_owner [8];
  int m_issued[8];
  int m_rr, m_mode, m_cyc;   // m_mode: 0 run, 1 draining, 2 done

  always @(negedge clk) begin : mdl
    int            outst [N];
    int            fid, w, ro, c;
    logic          iss, all_free;
    logic [N-1:0]  e_grant, e_rsp;
    logic [7:0]    tmo;
    if (!rst_b) begin
      for (int j = 0; j < 8; j++) begin m_owner[j] = -1; m_issued[j] = 0; end
      m_rr = 0; m_mode = 0; m_cyc = 0;
      check("rst_grant", cl_grant, 0);
      check("rst_req", {exe_req_req, exe_req_type, exe_req_id}, 0);
      check("rst_rsp", cl_rsp, 0);
      check("rst_flags", {flush_done, err_spurious, err_timeout}, 0);
    end else begin
      for (int i = 0; i < N; i++) outst[i] = 0;
      for (int j = 0; j < 8; j++) if (m_owner[j] >= 0) outst[m_owner[j]]++;
      fid = -1;
      for (int j = 7; j >= 0; j--) if (m_owner[j] < 0) fid = j;
      w = -1;
      for (int k = 0; k < N; k++) begin
        c = (m_rr + k) % N;
        if (w < 0 && cl_req[c] && outst[c] < MO) w = c;
      end
      iss = (m_mode == 0) && !exe_fifo_full && (fid >= 0) && (w >= 0);
      e_grant = '0;
      if (iss) e_grant[w] = 1'b1;
      ro = exe_rsp_rsp ? m_owner[exe_rsp_id] : -1;
      e_rsp = '0;
      if (ro >= 0) e_rsp[ro] = 1'b1;
      tmo = '0;
`ifdef SCHED_TIMEOUT_EN
      for (int j = 0; j < 8; j++)
        if (m_owner[j] >= 0 && (m_cyc - m_issued[j]) == TO && !(ro >= 0 && exe_rsp_id == 3'(j)))
          tmo[j] = 1'b1;
`endif
      check("m_grant", cl_grant, e_grant);
      check("m_req", exe_req_req, iss);
      check("m_type", exe_req_type, iss ? cl_type[w] : 1'b0);
      check("m_id", exe_req_id, iss ? fid : 0);
      check("m_data1", exe_req_data1, iss ? cl_data1[w*DW +: DW] : 0);
      check("m_data2", exe_req_data2, iss ? cl_data2[w*DW +: DW] : 0);
      check("m_rsp", cl_rsp, e_rsp);
      check("m_rsp_data", cl_rsp_data, (ro >= 0) ? exe_rsp_data : 64'd0);
      check("m_spurious", err_spurious, exe_rsp_rsp && ro < 0);
      check("m_timeout", err_timeout, |tmo);
      check("m_flush_done", flush_done, m_mode == 2);
      // advance model state
      if (ro >= 0) m_owner[exe_rsp_id] = -1;
      for (int j = 0; j < 8; j++) if (tmo[j]) m_owner[j] = -1;
      if (iss) begin
        m_owner[fid]  = w;
        m_issued[fid] = m_cyc;
        m_rr          = (w + 1) % N;
      end
      all_free = 1'b1;
      for (int j = 0; j < 8; j++) if (m_owner[j] >= 0) all_free = 1'b0;
      case (m_mode)
        0:       if (flush_req) m_mode = 1;
        1:       if (all_free) m_mode = 2;
        default: m_mode = 0;
      endcase
      m_cyc++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic adv();
    @(posedge clk); #1;
  endtask

  task automatic rsp(input logic v, input logic [2:0] id, input logic [63:0] d);
    exe_rsp_rsp = v; exe_rsp_id = id; exe_rsp_data = d;
  endtask

  task automatic do_reset();
    cl_req = '0; cl_type = '0; exe_fifo_full = 1'b0; flush_req = 1'b0;
    rsp(1'b0, 3'd0, 64'd0);
    rst_b = 1'b0;
    repeat (2) adv();
    rst_b = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    rst_b = 1'b0;
    cl_req = '0; cl_type = '0; cl_data1 = '0; cl_data2 = '0;
    exe_fifo_full = 1'b0; flush_req = 1'b0;
    rsp(1'b0, 3'd0, 64'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_lit_grant", cl_grant, 0);
    check("rst_lit_done", flush_done, 0);
    adv();
    rst_b = 1'b1;

    // Single client: add 5+7, answered with 12 while client 0 asks again.
    cl_data1[0 +: DW] = 32'd5; cl_data2[0 +: DW] = 32'd7;
    cl_req = 4'b0001;
    @(negedge clk);
    check("t1_grant", cl_grant, 4'b0001);
    check("t1_id", exe_req_id, 0);
    check("t1_data", {exe_req_data1, exe_req_data2}, {32'd5, 32'd7});
    adv();
    rsp(1'b1, 3'd0, 64'd12);
    @(negedge clk);
    check("t1_rsp", cl_rsp, 4'b0001);
    check("t1_rsp_data", cl_rsp_data, 64'd12);
    check("t1_regrant_id", exe_req_id, 1);
    adv();
    cl_req = '0;
    rsp(1'b1, 3'd1, 64'h1_0000_0000);
    @(negedge clk);
    check("t1_rsp_hi", cl_rsp_data, 64'h1_0000_0000);
    adv();
    do_reset();

    // All four clients hold requests; eight IDs then a stall.
    for (int i = 0; i < N; i++) begin
      cl_data1[i*DW +: DW] = 32'(100 + i);
      cl_data2[i*DW +: DW] = 32'(200 + i);
    end
    cl_type = 4'b1010;
    cl_req  = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("t2_grant", cl_grant, 64'(1) << (k % 4));
      check("t2_id", exe_req_id, k);
      check("t2_type", exe_req_type, k % 2);
      check("t2_data1", exe_req_data1, 100 + k % 4);
      adv();
    end
    @(negedge clk);
    check("t2_stall", {cl_grant, exe_req_req}, 0);
    adv();
    rsp(1'b1, 3'd3, 64'd33);
    @(negedge clk);
    check("t2_stall_rsp", cl_grant, 0);
    check("t2_rsp_owner", cl_rsp, 4'b1000);
    adv();
    rsp(1'b0, 3'd0, 64'd0);
    @(negedge clk);
    check("t2_reuse_grant", cl_grant, 4'b0001);
    check("t2_reuse_id", exe_req_id, 3);
    adv();
    cl_req = '0;
    do_reset();
    rsp(1'b1, 3'd5, 64'd55);
    @(negedge clk);
    check("t2_late_spurious", err_spurious, 1);
    check("t2_late_no_rsp", cl_rsp, 0);
    adv();
    rsp(1'b0, 3'd0, 64'd0);

    // FIFO full for five cycles, client 2 waiting.
    cl_req = 4'b0100; exe_fifo_full = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("t3_full_grant", {cl_grant, exe_req_req}, 0);
      adv();
    end
    exe_fifo_full = 1'b0;
    @(negedge clk);
    check("t3_grant", cl_grant, 4'b0100);
    check("t3_id", exe_req_id, 0);
    adv();

    // Client 1 saturates at four outstanding; client 3 alone is served.
    cl_req = 4'b0010;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("t4_c1_grant", cl_grant, 4'b0010);
      check("t4_c1_id", exe_req_id, k + 1);
      adv();
    end
    cl_req = 4'b1010;
    @(negedge clk);
    check("t4_c3_grant_a", cl_grant, 4'b1000);
    check("t4_c3_id_a", exe_req_id, 5);
    adv();
    @(negedge clk);
    check("t4_c3_grant_b", cl_grant, 4'b1000);
    adv();
    rsp(1'b1, 3'd1, 64'd77);
    @(negedge clk);
    check("t4_c1_rsp", cl_rsp, 4'b0010);
    check("t4_c3_grant_c", cl_grant, 4'b1000);
    check("t4_c3_id_c", exe_req_id, 7);
    adv();
    rsp(1'b0, 3'd0, 64'd0);
    @(negedge clk);
    check("t4_c1_again", cl_grant, 4'b0010);
    check("t4_c1_again_id", exe_req_id, 1);
    adv();
    cl_req = '0;

    // Drain with IDs 1, 6 and 7 still busy.
    foreach (m_owner[j]) ;
    rsp(1'b1, 3'd0, 64'd1); adv();
    rsp(1'b1, 3'd2, 64'd2); adv();
    rsp(1'b1, 3'd3, 64'd3); adv();
    rsp(1'b1, 3'd4, 64'd4); adv();
    rsp(1'b1, 3'd5, 64'd5); adv();
    rsp(1'b0, 3'd0, 64'd0);
    flush_req = 1'b1;
    @(negedge clk);
    check("t5_done_early", flush_done, 0);
    adv();
    flush_req = 1'b0; cl_req = 4'b1111;
    rsp(1'b1, 3'd6, 64'd6);
    @(negedge clk);
    check("t5_drain_nogrant_a", cl_grant, 0);
    check("t5_drain_rsp", cl_rsp, 4'b1000);
    adv();
    rsp(1'b1, 3'd7, 64'd7);
    @(negedge clk);
    check("t5_drain_nogrant_b", cl_grant, 0);
    adv();
    rsp(1'b1, 3'd1, 64'd8);
    flush_req = 1'b1;
    @(negedge clk);
    check("t5_drain_nogrant_c", cl_grant, 0);
    check("t5_not_done", flush_done, 0);
    adv();
    flush_req = 1'b0;
    rsp(1'b1, 3'd6, 64'd9);
    @(negedge clk);
    check("t5_done", flush_done, 1);
    check("t5_spurious", err_spurious, 1);
    check("t5_done_nogrant", cl_grant, 0);
    adv();
    rsp(1'b0, 3'd0, 64'd0);
    @(negedge clk);
    check("t5_done_pulse", flush_done, 0);
    check("t5_resume_grant", cl_grant, 4'b0100);
    check("t5_resume_id", exe_req_id, 0);
    adv();
    cl_req = '0;
    rsp(1'b1, 3'd0, 64'd10);
    adv();
    rsp(1'b0, 3'd0, 64'd0);
    flush_req = 1'b1;
    @(negedge clk);
    check("t5_idle_d0", flush_done, 0);
    adv();
    flush_req = 1'b0;
    @(negedge clk);
    check("t5_idle_d1", flush_done, 0);
    adv();
    @(negedge clk);
    check("t5_idle_d2", flush_done, 1);
    adv();
    @(negedge clk);
    check("t5_idle_d3", flush_done, 0);
    adv();

    // ID 0 never answered.
    do_reset();
    cl_req = 4'b0001;
    @(negedge clk);
    check("t6_grant", exe_req_id, 0);
    adv();
    cl_req = '0;
`ifdef SCHED_TIMEOUT_EN
    for (int k = 1; k < TO; k++) begin
      @(negedge clk);
      check("t6_no_timeout_yet", err_timeout, 0);
      adv();
    end
    @(negedge clk);
    check("t6_timeout", err_timeout, 1);
    check("t6_timeout_no_rsp", cl_rsp, 0);
    adv();
    cl_req = 4'b0001;
    @(negedge clk);
    check("t6_reissue_grant", cl_grant, 4'b0001);
    check("t6_reissue_id", exe_req_id, 0);
    check("t6_timeout_pulse", err_timeout, 0);
    adv();
    cl_req = '0;
`else
    for (int k = 1; k < 15; k++) begin
      @(negedge clk);
      check("t6_timeout_off", err_timeout, 0);
      adv();
    end
    cl_req = 4'b0001;
    @(negedge clk);
    check("t6_id_still_busy", exe_req_id, 1);
    adv();
    cl_req = '0;
`endif
    repeat (2) adv();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/exec_req_scheduler.md
Name: exec_req_scheduler

Overview:
- Front-end scheduler for the execution unit: shares the unit among NUM_REQ client requesters using round-robin arbitration.
- Allocates the 3-bit request IDs, issues req_pkt_type packets into the execution unit and respects fifo_full.
- Tracks ID ownership so each rsp_pkt_type response is routed back to the client that issued it.
- Provides a drain handshake so software/test can quiesce the unit.

Parameters:
- NUM_REQ, 4, number of client requesters (2..8)
- MAX_OUTST, 4, max in-flight requests per client
- DATA_W, 32, operand width per client data bus (matches req_data1/req_data2)
- TIMEOUT_CYC, 255, response timeout in cycles (used only with optional feature)

Ports:
- clk  in  1  clock
- rst_b  in  1  asynchronous active-low reset
- cl_req  in  NUM_REQ  per-client request valid, held until granted
- cl_type  in  NUM_REQ  per-client op: 1=mul, 0=add
- cl_data1  in  NUM_REQ*DATA_W  per-client operand 1, packed, client i at [i*DATA_W +: DATA_W]
- cl_data2  in  NUM_REQ*DATA_W  per-client operand 2, packed
- cl_grant  out  NUM_REQ  one-hot grant, combinational, same cycle as issue
- cl_rsp  out  NUM_REQ  one-hot response valid, 1-cycle pulse
- cl_rsp_data  out  64  response data, valid with cl_rsp
- exe_req  out  req_pkt_type  packet to execution unit
- exe_fifo_full  in  1  execution unit input FIFO full
- exe_rsp  in  rsp_pkt_type  response from execution unit
- flush_req  in  1  drain request pulse
- flush_done  out  1  drain complete, 1-cycle pulse
- err_spurious  out  1  response for an unallocated ID, 1-cycle pulse
- err_timeout  out  1  timeout detected, 1-cycle pulse

Behaviour:
- Reset (async assert, sync release): all 8 IDs free; owner table 0; per-client outstanding counters 0; RR pointer 0 (client 0 highest priority); FSM=RUN.
- Outputs at reset: cl_grant=0, cl_rsp=0, cl_rsp_data=0, exe_req all fields 0, flush_done=0, err_*=0.
- Reset mid-operation discards all in-flight tracking; late responses after reset flag err_spurious.
- Eligibility: client i is eligible when cl_req[i]=1 and outstanding[i]<MAX_OUTST.
- Issue conditions: FSM=RUN, exe_fifo_full=0, at least one ID free, at least one eligible client.
- Arbitration: the first eligible client at or after the RR pointer, with wrap-around, wins.
- On issue:
  - cl_grant[w]=1 in the same cycle.
  - exe_req.req=1, req_type=cl_type[w], req_id=lowest-numbered free ID, data from client w, all combinational in the same cycle.
  - Registered at the clock edge: ID marked busy, owner[id]=w, outstanding[w]++, RR pointer = w+1 mod NUM_REQ.
- No issue: exe_req.req=0; other exe_req fields 0; cl_grant=0; RR pointer unchanged.
- Response: exe_rsp.rsp=1 and ID busy →
  - cl_rsp[owner]=1 and cl_rsp_data=rsp_data, combinational, same cycle.
  - At the edge: ID freed, outstanding[owner]--.
  - A freed ID is allocatable from the next cycle.
- Response to a free ID: no cl_rsp; err_spurious=1 for that cycle; no state change.
- Issue and response for the same client in one cycle: outstanding unchanged.
- All 8 IDs busy: no issue regardless of eligible clients.
- FSM:
  - RUN: flush_req → DRAIN.
  - DRAIN: no new issues; when all IDs are free → DONE.
  - DONE: flush_done=1 for one cycle → RUN.
  - flush_req while in DRAIN or DONE is ignored.
  - flush_req with nothing outstanding: DRAIN→DONE takes 1 cycle, flush_done asserts 2 cycles after flush_req.

Optional Feature:
- Macro SCHED_TIMEOUT_EN.
- When defined:
  - Each busy ID has an age counter, cleared at allocation and incremented every cycle while busy.
  - When a counter reaches TIMEOUT_CYC, the ID is force-freed and the owner's outstanding is decremented; no cl_rsp is issued; err_timeout pulses 1 cycle.
  - Timeout and genuine response on the same ID in the same cycle: the response wins and no err_timeout is raised.
  - Multiple simultaneous timeouts free all affected IDs and raise a single err_timeout pulse.
- When undefined: no age counters; err_timeout tied 0; IDs are freed only by responses.

Test Plan:
- Single client 0 requests add, data1=5, data2=7 → cl_grant[0] same cycle, exe_req.req_id=0; rsp_id=0 data=12 → cl_rsp[0]=1, cl_rsp_data=12.
- Clients 0..3 hold cl_req continuously, fifo never full, responses delayed → grant order 0,1,2,3,0; IDs 0..7 issued; 9th grant stalls until an ID returns.
- exe_fifo_full=1 for 5 cycles with client 2 requesting → no grant and exe_req.req=0 for all 5 cycles; grant on the first cycle full drops.
- Client 1 reaches 4 outstanding while client 3 requests → only client 3 granted until a client-1 response arrives.
- flush_req with 3 IDs busy → no grants; flush_done pulses the cycle after the last response clears; rsp_id=6 while free → err_spurious=1.
- SCHED_TIMEOUT_EN, TIMEOUT_CYC=10, ID 0 never answered → err_timeout pulses 10 cycles after issue, ID 0 reissued next; without the macro err_timeout stays 0.
